// File: rtl/uart_iomem_bridge.sv
// UART-to-iomem debug bridge: decodes 'W'/'R' byte commands from a UART receiver,
// runs one 32-bit iomem transaction as initiator and streams the reply bytes back out.
module uart_iomem_bridge #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        busy
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          is_wr_q, is_wr_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          valid_q, valid_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   resp_q, resp_d;
    logic [1:0]    left_q, left_d;
    logic          txv_q, txv_d;

    logic cmd_w, cmd_r, tx_fire, tmo_hit;
    assign cmd_w   = (rx_data == 8'h57);
    assign cmd_r   = (rx_data == 8'h52);
    assign tx_fire = txv_q && tx_ready;
    // The TIMEOUT-th valid cycle is the last chance; ready on it still wins.
    assign tmo_hit = (tmo_q == TMO_LAST) && !iomem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            valid_q <= 1'b0;
            tmo_q   <= '0;
            resp_q  <= '0;
            left_q  <= '0;
            txv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
            resp_q  <= resp_d;
            left_q  <= left_d;
            txv_q   <= txv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (rx_valid) state_d = (cmd_w || cmd_r) ? S_ADDR : S_RESP;
            S_ADDR: if (rx_valid && cnt_q == 2'd3) state_d = is_wr_q ? S_DATA : S_BUS;
            S_DATA: if (rx_valid && cnt_q == 2'd3) state_d = S_BUS;
            S_BUS:  if (iomem_ready || tmo_hit) state_d = S_RESP;
            S_RESP: if (tx_fire && left_q == 2'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        valid_d = valid_q;
        tmo_d   = tmo_q;
        resp_d  = resp_q;
        left_d  = left_q;
        txv_d   = txv_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 2'd0;
                if (rx_valid) begin
                    is_wr_d = cmd_w;
                    if (!(cmd_w || cmd_r)) begin
                        resp_d = {8'h3F, 24'h0};
                        left_d = 2'd0;
                        txv_d  = 1'b1;
                    end
                end
            end
            S_ADDR: if (rx_valid) begin
                addr_d = {addr_q[23:0], rx_data};
                cnt_d  = cnt_q + 2'd1;
            end
            S_DATA: if (rx_valid) begin
                wdata_d = {wdata_q[23:0], rx_data};
                cnt_d   = cnt_q + 2'd1;
            end
            S_BUS: begin
                if (iomem_ready) begin
                    resp_d  = is_wr_q ? {8'h4B, 24'h0} : iomem_rdata;
                    left_d  = is_wr_q ? 2'd0 : 2'd3;
                    valid_d = 1'b0;
                    txv_d   = 1'b1;
                end else if (tmo_hit) begin
                    resp_d  = {8'h54, 24'h0};
                    left_d  = 2'd0;
                    valid_d = 1'b0;
                    txv_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RESP: if (tx_fire) begin
                if (left_q == 2'd0) begin
                    txv_d = 1'b0;
                end else begin
                    resp_d = {resp_q[23:0], 8'h00};
                    left_d = left_q - 2'd1;
                end
            end
            default: ;
        endcase
        // Request launches on the edge that accepts the final command byte.
        if (state_d == S_BUS && state_q != S_BUS) begin
            valid_d = 1'b1;
            wstrb_d = is_wr_q ? 4'hF : 4'h0;
            tmo_d   = '0;
        end
    end

    assign tx_valid    = txv_q;
    assign tx_data     = resp_q[31:24];
    assign iomem_valid = valid_q;
    assign iomem_wstrb = wstrb_q;
    assign iomem_addr  = addr_q;
    assign iomem_wdata = wdata_q;
    assign busy        = (state_q != S_IDLE);
endmodule
